// File: rtl/game_pkg.sv
// Shared game types: top-level state, sound-effect ids and the BCD score width.
// Also used by the UI overlay and the sound unit.
package game_pkg;

  // Width of the three-digit BCD score.
  localparam int BCD_W = 12;

  // Highest value a three-digit BCD score can hold.
  localparam logic [BCD_W-1:0] BCD_MAX = 12'h999;

  typedef enum logic [1:0] {
    MENU    = 2'd0,
    PLAYING = 2'd1,
    DEAD    = 2'd2,
    WIN     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    UI_PRESS    = 2'd0,
    NEXTLEVEL   = 2'd1,
    CRASH       = 2'd2,
    CELEBRATION = 2'd3
  } sound_t;

endpackage

// File: rtl/game_ctrl_bcd_add_sat.sv
// Combinational three-digit BCD adder. Each digit carries decimally; a carry
// out of the hundreds digit clamps the result to 999 so no A-F code can appear.
module bcd_add_sat
  import game_pkg::*;
(
  input  logic [BCD_W-1:0] score,
  input  logic [BCD_W-1:0] addend,
  output logic [BCD_W-1:0] sum
);

  logic [BCD_W-1:0] sum_raw;
  logic [4:0]       dsum;
  logic             carry;

  // Ripple the decimal carry digit by digit, then saturate on overflow.
  // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    sum_raw = '0;
    dsum    = '0;
    carry   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dsum = {1'b0, score[i*4 +: 4]} + {1'b0, addend[i*4 +: 4]} + {4'b0000, carry};
      if (dsum > 5'd9) begin
        dsum  = dsum - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum_raw[i*4 +: 4] = dsum[3:0];
    end
    sum = carry ? BCD_MAX : sum_raw;
  end

endmodule

// File: rtl/game_ctrl.sv
// Frogger game sequencer: MENU/PLAYING/DEAD/WIN state, BCD score, level
// counter, end-of-game hold timer and the sound-effect request register.
module game_ctrl
  import game_pkg::*;
#(
  parameter int               MAX_LEVEL   = 5,
  parameter int               HOLD_FRAMES = 60,
  parameter logic [BCD_W-1:0] GOAL_POINTS = 12'h010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             any_key,
  input  logic             hop,
  input  logic             collision,
  input  logic             goal,
  input  logic             sound_ack,
  output logic [1:0]       state,
  output logic [BCD_W-1:0] score_bcd,
  output logic [3:0]       level,
  output logic             sound_req,
  output logic [1:0]       sound_id
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);

  state_t           state_q, state_d;
  logic [BCD_W-1:0] score_q, score_d;
  logic [3:0]       level_q, level_d;
  logic [HW-1:0]    hold_q,  hold_d;
  logic             req_q,   req_d;
  sound_t           id_q,    id_d;
  logic             key_prev;
  logic             key_rise;
  logic             raise;
  sound_t           raise_id;
  logic [BCD_W-1:0] addend;
  logic [BCD_W-1:0] score_sum;

  assign key_rise = any_key & ~key_prev;

  // A goal scores GOAL_POINTS; otherwise the only scoring event is a hop.
  assign addend = goal ? GOAL_POINTS : 12'h001;

  bcd_add_sat u_add (
    .score  (score_q),
    .addend (addend),
    .sum    (score_sum)
  );

  // Key edge detector; starts high so a key held through reset is not a press.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_prev <= 1'b1;
    else        key_prev <= any_key;
  end

  // State, score, level, hold timer and sound request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MENU;
      score_q <= '0;
      level_q <= '0;
      hold_q  <= '0;
      req_q   <= 1'b0;
      id_q    <= UI_PRESS;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      level_q <= level_d;
      hold_q  <= hold_d;
      req_q   <= req_d;
      id_q    <= id_d;
    end
  end

  // Next-state logic: game transitions, scoring and sound raises.
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    level_d  = level_q;
    hold_d   = hold_q;
    req_d    = req_q & ~sound_ack;
    id_d     = id_q;
    raise    = 1'b0;
    raise_id = UI_PRESS;

    case (state_q)
      MENU: begin
        if (key_rise) begin
          state_d  = PLAYING;
          score_d  = '0;
          level_d  = 4'd1;
          raise    = 1'b1;
          raise_id = UI_PRESS;
        end
      end
      PLAYING: begin
        // Only the highest-priority event of the cycle acts.
        if (collision) begin
          state_d  = DEAD;
          hold_d   = '0;
          raise    = 1'b1;
          raise_id = CRASH;
        end else if (goal) begin
          score_d = score_sum;
          raise   = 1'b1;
          if (level_q == MAX_LEVEL[3:0]) begin
            state_d  = WIN;
            hold_d   = '0;
            raise_id = CELEBRATION;
          end else begin
            level_d  = level_q + 4'd1;
            raise_id = NEXTLEVEL;
          end
        end else if (hop) begin
          score_d = score_sum;
        end
      end
      DEAD, WIN: begin
        if (frame_tick && (hold_q != HOLD_FRAMES[HW-1:0])) hold_d = hold_q + 1'b1;
        // The release check uses the count before this cycle's tick.
        if (key_rise && (hold_q == HOLD_FRAMES[HW-1:0])) begin
          state_d  = MENU;
          level_d  = '0;
          hold_d   = '0;
          raise    = 1'b1;
          raise_id = UI_PRESS;
        end
      end
      default: state_d = MENU;
    endcase

    // A new sound overrides both a pending request and a same-cycle ack.
    if (raise) begin
      req_d = 1'b1;
      id_d  = raise_id;
    end
  end

  assign state     = state_q;
  assign score_bcd = score_q;
  assign level     = level_q;
  assign sound_req = req_q;
  assign sound_id  = id_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: expectations are queued as stimulus is
// driven and compared once the DUT has had its clock edge.
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick, any_key, hop, collision, goal, sound_ack;
  logic [1:0]  state;
  logic [11:0] score_bcd;
  logic [3:0]  level;
  logic        sound_req;
  logic [1:0]  sound_id;

  int checks   = 0;
  int failures = 0;

  typedef enum int { O_STATE, O_SCORE, O_LEVEL, O_REQ, O_ID } obs_t;

  typedef struct {
    string       tag;
    obs_t        sel;
    logic [11:0] val;
  } exp_t;

  exp_t sb[$];

  game_ctrl #(
    .MAX_LEVEL   (5),
    .HOLD_FRAMES (60),
    .GOAL_POINTS (12'h010)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .any_key    (any_key),
    .hop        (hop),
    .collision  (collision),
    .goal       (goal),
    .sound_ack  (sound_ack),
    .state      (state),
    .score_bcd  (score_bcd),
    .level      (level),
    .sound_req  (sound_req),
    .sound_id   (sound_id)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] observe(obs_t sel);
    case (sel)
      O_STATE: return {10'd0, state};
      O_SCORE: return score_bcd;
      O_LEVEL: return {8'd0, level};
      O_REQ:   return {11'd0, sound_req};
      default: return {10'd0, sound_id};
    endcase
  endfunction

  task automatic push(input string tag, input obs_t sel, input logic [11:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  // Queue a full snapshot of all outputs.
  task automatic push_all(input string tag, input logic [1:0] st, input logic [11:0] sc,
                          input logic [3:0] lv, input logic rq, input logic [1:0] id);
    push({tag, ".state"}, O_STATE, {10'd0, st});
    push({tag, ".score"}, O_SCORE, sc);
    push({tag, ".level"}, O_LEVEL, {8'd0, lv});
    push({tag, ".req"},   O_REQ,   {11'd0, rq});
    push({tag, ".id"},    O_ID,    {10'd0, id});
  endtask

  task automatic drain();
    exp_t        e;
    logic [11:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic idle_inputs();
    frame_tick = 1'b0; hop = 1'b0; collision = 1'b0; goal = 1'b0; sound_ack = 1'b0;
  endtask

  initial begin
    idle_inputs();
    any_key = 1'b1;
    rst_n   = 1'b0;
    #2;
    push_all("reset", 2'd0, 12'h000, 4'd0, 1'b0, 2'd0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;

    // Key held through reset must not start a game.
    tick(); tick();
    push("held_key", O_STATE, 12'd0);
    tick();
    any_key = 1'b0;
    push("released", O_STATE, 12'd0);
    tick();
    any_key = 1'b1;
    push_all("start", 2'd1, 12'h000, 4'd1, 1'b1, 2'd0);
    tick();
    any_key = 1'b0;

    // UI_PRESS stays pending (no ack) across 12 back-to-back hops.
    hop = 1'b1;
    repeat (11) tick();
    push("hop12.score", O_SCORE, 12'h012);
    push("hop12.req",   O_REQ,   12'd1);
    push("hop12.id",    O_ID,    12'd0);
    tick();
    hop = 1'b0;

    // Goal replaces the pending id; request stays high.
    goal = 1'b1;
    push_all("goal1", 2'd1, 12'h022, 4'd2, 1'b1, 2'd1);
    tick();
    goal = 1'b0;

    // Ack alone clears the request on the next edge; ack while idle is ignored.
    sound_ack = 1'b1;
    push("ack.req", O_REQ, 12'd0);
    tick();
    push("ack_idle.req", O_REQ, 12'd0);
    push("ack_idle.id",  O_ID,  12'd1);
    tick();
    sound_ack = 1'b0;

    // Goal, then a goal coinciding with an ack: the new request wins.
    goal = 1'b1;
    push_all("goal2", 2'd1, 12'h032, 4'd3, 1'b1, 2'd1);
    tick();
    sound_ack = 1'b1;
    push_all("goal_ack", 2'd1, 12'h042, 4'd4, 1'b1, 2'd1);
    tick();
    goal = 1'b0;
    push("ack2.req", O_REQ, 12'd0);
    tick();
    sound_ack = 1'b0;

    // Bring the score to 050, then collide with goal and hop in the same cycle.
    hop = 1'b1;
    repeat (7) tick();
    push("hop50.score", O_SCORE, 12'h050);
    tick();
    collision = 1'b1; goal = 1'b1;
    push_all("prio", 2'd2, 12'h050, 4'd4, 1'b1, 2'd2);
    tick();
    idle_inputs();

    // Events are ignored in DEAD; ack clears the crash request.
    hop = 1'b1; goal = 1'b1; collision = 1'b1; sound_ack = 1'b1;
    push_all("dead_ignore", 2'd2, 12'h050, 4'd4, 1'b0, 2'd2);
    tick();
    idle_inputs();

    // 59 frame ticks, then a press: too early.
    frame_tick = 1'b1;
    repeat (59) tick();
    frame_tick = 1'b0;
    any_key = 1'b1;
    push("hold59.state", O_STATE, 12'd2);
    tick();
    any_key = 1'b0;
    tick();
    // Press coincident with the 60th tick compares against 59: still ignored.
    frame_tick = 1'b1; any_key = 1'b1;
    push("hold59_tick.state", O_STATE, 12'd2);
    tick();
    frame_tick = 1'b0; any_key = 1'b0;
    tick();
    // Now the hold has elapsed.
    any_key = 1'b1;
    push_all("to_menu", 2'd0, 12'h050, 4'd0, 1'b1, 2'd0);
    tick();
    any_key = 1'b0;
    tick();

    // Second game: start, three goals, then hops up to 995.
    any_key = 1'b1; sound_ack = 1'b1;
    push_all("start2", 2'd1, 12'h000, 4'd1, 1'b1, 2'd0);
    tick();
    any_key = 1'b0; sound_ack = 1'b0;
    goal = 1'b1;
    repeat (2) tick();
    push("goal3x.level", O_LEVEL, 12'd4);
    push("goal3x.score", O_SCORE, 12'h030);
    tick();
    goal = 1'b0;
    hop = 1'b1;
    repeat (964) tick();
    push("s995.score", O_SCORE, 12'h995);
    tick();
    hop = 1'b0;

    // 995 + 010 saturates; a further hop stays at 999.
    goal = 1'b1;
    push_all("sat_goal", 2'd1, 12'h999, 4'd5, 1'b1, 2'd1);
    tick();
    goal = 1'b0; hop = 1'b1;
    push("sat_hop.score", O_SCORE, 12'h999);
    tick();
    hop = 1'b0;

    // Goal at the last level wins.
    goal = 1'b1;
    push_all("win", 2'd3, 12'h999, 4'd5, 1'b1, 2'd3);
    tick();
    goal = 1'b0;

    // Reset mid-request and mid-hold takes effect without a clock edge.
    frame_tick = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    push_all("async_rst", 2'd0, 12'h000, 4'd0, 1'b0, 2'd0);
    drain();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    push("post_rst.state", O_STATE, 12'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
